// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM arbiter slice.
// Holds the round-robin grant rule used by rr_arbiter2.
package ram_pkg;

  localparam int DATA_W    = 32;
  localparam int S_DEFAULT = 12;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    rd_valid;
    req_id_t owner;
  } trk_stage_t;

  // Grant vector {grant1, grant0}; on contention the requester not served last wins.
  function automatic logic [1:0] rr_grant(
    input logic    v0,
    input logic    v1,
    input req_id_t last
  );
    logic [1:0] g;
    if (v0 && v1) begin
      if (last == 1'b1) begin
        g = 2'b01;
      end else begin
        g = 2'b10;
      end
    end else begin
      g = {v1, v0};
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered
// record of the most recently accepted requester.
module rr_arbiter2
  import ram_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid0,
  input  logic    valid1,
  output logic    grant0,
  output logic    grant1,
  output req_id_t winner,
  output logic    accept
);

  logic [1:0] grant_s;
  req_id_t    last_r;

  // Grant decode from the two valids and the last-served pointer.
  always_comb begin
    grant_s = rr_grant(valid0, valid1, last_r);
    grant0  = grant_s[0];
    grant1  = grant_s[1];
    accept  = grant_s[0] | grant_s[1];
    winner  = grant_s[1];
  end

  // Last-served pointer; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= 1'b1;
    end else if (accept) begin
      last_r <= winner;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two valid/ready requesters; issues
// registered commands and routes read data back after a 2-stage tracker.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int S = S_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [S-1:0]      req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [S-1:0]      req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [S-1:0]      ram_address,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  logic              grant0_s;
  logic              grant1_s;
  logic              accept_s;
  req_id_t           winner_s;
  logic              sel_write_s;
  logic [S-1:0]      sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  trk_stage_t        trk_in_s;
  trk_stage_t        trk1_r;
  trk_stage_t        trk2_r;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0_s),
    .grant1 (grant1_s),
    .winner (winner_s),
    .accept (accept_s)
  );

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Select the winning requester's command.
  always_comb begin
    sel_write_s = req0_write;
    sel_addr_s  = req0_addr;
    sel_wdata_s = req0_wdata;
    if (winner_s == 1'b1) begin
      sel_write_s = req1_write;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
    end else begin
      sel_write_s = req0_write;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
    end
  end

  // Tracker entry for the command accepted this cycle.
  always_comb begin
    trk_in_s.rd_valid = accept_s && !sel_write_s;
    trk_in_s.owner    = winner_s;
  end

  // Issue registers; address and data hold when idle so the RAM sees no spurious write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_address <= {S{1'b0}};
      ram_write   <= 1'b0;
      ram_dataIn  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      ram_address <= sel_addr_s;
      ram_write   <= sel_write_s;
      ram_dataIn  <= sel_wdata_s;
    end else begin
      ram_write   <= 1'b0;
    end
  end

  // Two-stage read tracker aligned with the RAM's registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk1_r.rd_valid <= 1'b0;
      trk1_r.owner    <= 1'b0;
      trk2_r.rd_valid <= 1'b0;
      trk2_r.owner    <= 1'b0;
    end else begin
      trk1_r <= trk_in_s;
      trk2_r <= trk1_r;
    end
  end

  // Response registers; only the owner's rdata is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= {DATA_W{1'b0}};
      rsp1_rdata <= {DATA_W{1'b0}};
    end else begin
      rsp0_valid <= trk2_r.rd_valid && (trk2_r.owner == 1'b0);
      rsp1_valid <= trk2_r.rd_valid && (trk2_r.owner == 1'b1);
      if (trk2_r.rd_valid && (trk2_r.owner == 1'b0)) begin
        rsp0_rdata <= ram_dataOut;
      end
      if (trk2_r.rd_valid && (trk2_r.owner == 1'b1)) begin
        rsp1_rdata <= ram_dataOut;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and an
// accept-order memory model; a negedge monitor checks every response.
module tb_ram_arbiter;
  import ram_pkg::*;

  localparam int S     = 12;
  localparam int DEPTH = 1 << S;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_write, req0_ready;
  logic        req1_valid, req1_write, req1_ready;
  logic [S-1:0] req0_addr, req1_addr, ram_address;
  logic [31:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
  logic        rsp0_valid, rsp1_valid, ram_write;
  logic [31:0] ram_dataIn, ram_dataOut;

  always #5 clk = ~clk;

  ram_arbiter #(.S(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_address(ram_address), .ram_write(ram_write),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  // Single-port RAM: read-before-write, registered output, cleared on reset.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'h0;
      ram_dataOut <= 32'h0;
    end else begin
      ram_dataOut <= ram_mem[ram_address];
      if (ram_write) ram_mem[ram_address] <= ram_dataIn;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] hold[2];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  // Reference state: memory as seen in accept order, last-served requester, pending requests.
  logic [31:0] mem_m [DEPTH];
  logic        m_last;
  logic        pv[2];
  logic        pw[2];
  logic [S-1:0] pa[2];
  logic [31:0] pd[2];

  task automatic mon_port(input int id, input logic v, input logic [31:0] d);
    exp_t e;
    bit   have;
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (id == 0) e = q0[0];
      else e = q1[0];
    end
    if (v) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL rsp%0d_unexpected: pulse with data %h at cycle %0d, required no pulse", id, d, cyc);
      end else begin
        if (id == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        if (d !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rsp%0d_data: got %h at cycle %0d, required %h at cycle %0d", id, d, cyc, e.data, e.due);
        end
        hold[id] = e.data;
      end
    end else begin
      if (have && e.due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp%0d_missing: no pulse at cycle %0d, required %h", id, cyc, e.data);
        if (id == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
      checks++;
      if (d !== hold[id]) begin
        errors++;
        $display("FAIL rsp%0d_hold: rdata %h, required %h", id, d, hold[id]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst === 1'b1) begin
      mon_port(0, rsp0_valid, rsp0_rdata);
      mon_port(1, rsp1_valid, rsp1_rdata);
      checks++;
      if (rsp0_valid && rsp1_valid) begin
        errors++;
        $display("FAIL rsp_both: rsp0_valid and rsp1_valid both 1, required at most one");
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_zero();
    chk("reset_ram_address", 32'(ram_address), 32'h0);
    chk("reset_ram_write", 32'(ram_write), 32'h0);
    chk("reset_ram_dataIn", ram_dataIn, 32'h0);
    chk("reset_rsp0_valid", 32'(rsp0_valid), 32'h0);
    chk("reset_rsp1_valid", 32'(rsp1_valid), 32'h0);
    chk("reset_rsp0_rdata", rsp0_rdata, 32'h0);
    chk("reset_rsp1_rdata", rsp1_rdata, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    q0.delete();
    q1.delete();
    hold[0] = 32'h0;
    hold[1] = 32'h0;
    m_last = 1'b1;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
  endtask

  task automatic drive();
    req0_valid = pv[0]; req0_write = pw[0]; req0_addr = pa[0]; req0_wdata = pd[0];
    req1_valid = pv[1]; req1_write = pw[1]; req1_addr = pa[1]; req1_wdata = pd[1];
  endtask

  task automatic set_req(input int id, input logic w, input logic [S-1:0] a, input logic [31:0] d);
    pv[id] = 1'b1;
    pw[id] = w;
    pa[id] = a;
    pd[id] = d;
  endtask

  task automatic accept(input int id);
    exp_t e;
    if (pw[id]) begin
      mem_m[pa[id]] = pd[id];
    end else begin
      e.data = mem_m[pa[id]];
      e.due  = cyc + 3;
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    m_last = (id == 1);
    pv[id] = 1'b0;
  endtask

  // One clock: present pending requests, check ready against the round-robin rule, record accept.
  task automatic cycle();
    logic g0, g1;
    drive();
    @(negedge clk);
    g0 = pv[0] && (!pv[1] || m_last == 1'b1);
    g1 = pv[1] && (!pv[0] || m_last == 1'b0);
    checks++;
    if ({req1_ready, req0_ready} !== {g1, g0}) begin
      errors++;
      $display("FAIL grant: ready {1,0}=%b%b at cycle %0d, required %b%b", req1_ready, req0_ready, cyc, g1, g0);
    end
    if (g0) accept(0);
    else if (g1) accept(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && (pv[0] || pv[1]); i++) cycle();
    repeat (3) cycle();
  endtask

  initial begin
    rst = 1'b0;
    pw[0] = 1'b0; pw[1] = 1'b0;
    pa[0] = '0;   pa[1] = '0;
    pd[0] = 32'h0; pd[1] = 32'h0;
    model_reset();
    drive();
    repeat (3) @(negedge clk);
    check_zero();
    chk("reset_ready0", 32'(req0_ready), 32'h0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Read of a freshly reset location.
    set_req(0, 1'b0, 12'h000, 32'h0);
    cycle();
    drain();

    // Write then immediate read of the same address from the other requester.
    set_req(0, 1'b1, 12'h010, 32'hDEADBEEF);
    cycle();
    set_req(1, 1'b0, 12'h010, 32'h0);
    cycle();
    drain();

    // Continuous contention: grants and responses alternate.
    set_req(0, 1'b1, 12'h001, 32'hA5A5_0001);
    set_req(1, 1'b1, 12'h002, 32'h5A5A_0002);
    drain();
    repeat (8) begin
      if (!pv[0]) set_req(0, 1'b0, 12'h001, 32'h0);
      if (!pv[1]) set_req(1, 1'b0, 12'h002, 32'h0);
      cycle();
    end
    drain();

    // req1 loses one contention and must be served next with its command unchanged.
    set_req(1, 1'b0, 12'h010, 32'h0);
    cycle();
    set_req(0, 1'b1, 12'h020, 32'h1234_5678);
    set_req(1, 1'b1, 12'h021, 32'hCAFE_F00D);
    drain();
    set_req(0, 1'b0, 12'h021, 32'h0);
    set_req(1, 1'b0, 12'h020, 32'h0);
    drain();

    // Back-to-back reads across a preloaded boundary.
    set_req(0, 1'b1, 12'h0FF, 32'h0000_0011);
    cycle();
    set_req(0, 1'b1, 12'h100, 32'h0000_0022);
    cycle();
    set_req(0, 1'b0, 12'h0FF, 32'h0);
    cycle();
    set_req(0, 1'b0, 12'h100, 32'h0);
    cycle();
    drain();

    // Reset with a read in flight: no response, outputs cleared at once.
    set_req(0, 1'b0, 12'h0FF, 32'h0);
    cycle();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_zero();
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 12'h0FF, 32'h0);
    set_req(1, 1'b0, 12'h100, 32'h0);
    drain();

    // Random traffic over a small address window to force hazards.
    repeat (400) begin
      for (int id = 0; id < 2; id++) begin
        if (!pv[id] && $urandom_range(0, 99) < 60)
          set_req(id, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      end
      cycle();
    end
    drain();
    repeat (2) cycle();

    chk("queue0_empty", 32'(q0.size()), 32'h0);
    chk("queue1_empty", 32'(q1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
